// File: rtl/ram_ctrl_pkg.sv
// Shared definitions for the RAM cell-array access controller.
// Optional feature macro: WRITE_VERIFY_EN (adds the VFY readback state).
package ram_ctrl_pkg;

   localparam int unsigned ADDR_W_DEF = 2;
   localparam int unsigned DATA_W_DEF = 4;

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      WR   = 3'd1,
      RD   = 3'd2,
      VFY  = 3'd3,
      RESP = 3'd4
   } state_t;

endpackage

// File: rtl/ram_addr_decoder.sv
// Binary word address to one-hot row select, gated by an enable.
// Purely combinational; the controller registers the result.
module ram_addr_decoder #(
   parameter int unsigned ADDR_W = 2
) (
   input  logic                     en,
   input  logic [ADDR_W-1:0]        addr,
   output logic [(2**ADDR_W)-1:0]   onehot
);

   // One row bit set for the addressed word, nothing when disabled
   always_comb begin
      onehot = '0;
      if (en) onehot[addr] = 1'b1;
   end

endmodule

// File: rtl/ram_access_ctrl.sv
// Request/response controller driving a WORDS x DATA_W array of one-bit cells.
// Decodes the address into registered one-hot row selects, sequences the
// w/r strobes and write data, captures the shared d_out bus on reads.
// Optional feature macro: WRITE_VERIFY_EN (write is followed by a readback
// cycle on the same row; response carries readback and a mismatch flag).
module ram_access_ctrl
   import ram_ctrl_pkg::*;
#(
   parameter int unsigned ADDR_W = ADDR_W_DEF,
   parameter int unsigned DATA_W = DATA_W_DEF
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     req_valid,
   output logic                     req_ready,
   input  logic                     req_we,
   input  logic [ADDR_W-1:0]        req_addr,
   input  logic [DATA_W-1:0]        req_wdata,
   output logic                     rsp_valid,
   input  logic                     rsp_ready,
   output logic [DATA_W-1:0]        rsp_rdata,
   output logic                     rsp_err,
   output logic [(2**ADDR_W)-1:0]   cell_cs,
   output logic                     cell_w,
   output logic                     cell_r,
   output logic [DATA_W-1:0]        cell_din,
   input  logic [DATA_W-1:0]        cell_dout
);

   localparam int unsigned WORDS = 2**ADDR_W;

   state_t            state;
   logic [WORDS-1:0]  sel;
`ifdef WRITE_VERIFY_EN
   logic [DATA_W-1:0] wdata_q;
`endif

   ram_addr_decoder #(.ADDR_W(ADDR_W)) u_dec (
      .en     (req_valid),
      .addr   (req_addr),
      .onehot (sel)
   );

   // Accept only when idle and not held in reset
   always_comb req_ready = (state == IDLE) && !rst;

   // Main sequencer: every cell_* and rsp_* output is a register.
   // The row select is loaded at the accept edge so the strobe cycle
   // already presents a stable, glitch-free cs/w/r/din set to the cells.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         cell_cs   <= '0;
         cell_w    <= 1'b0;
         cell_r    <= 1'b0;
         cell_din  <= '0;
         rsp_valid <= 1'b0;
         rsp_rdata <= '0;
         rsp_err   <= 1'b0;
`ifdef WRITE_VERIFY_EN
         wdata_q   <= '0;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (req_valid) begin
                  cell_cs  <= sel;
                  cell_w   <= req_we;
                  cell_r   <= !req_we;
                  cell_din <= req_we ? req_wdata : '0;
`ifdef WRITE_VERIFY_EN
                  wdata_q  <= req_wdata;
`endif
                  state    <= req_we ? WR : RD;
               end
            end
            WR: begin
               cell_w   <= 1'b0;
               cell_din <= '0;
`ifdef WRITE_VERIFY_EN
               // keep the row selected and turn it around into a read
               cell_r   <= 1'b1;
               state    <= VFY;
`else
               cell_cs   <= '0;
               rsp_valid <= 1'b1;
               rsp_rdata <= '0;
               rsp_err   <= 1'b0;
               state     <= RESP;
`endif
            end
            RD: begin
               cell_cs   <= '0;
               cell_r    <= 1'b0;
               rsp_rdata <= cell_dout;
               rsp_err   <= 1'b0;
               rsp_valid <= 1'b1;
               state     <= RESP;
            end
            VFY: begin
`ifdef WRITE_VERIFY_EN
               cell_cs   <= '0;
               cell_r    <= 1'b0;
               rsp_rdata <= cell_dout;
               rsp_err   <= (cell_dout != wdata_q);
               rsp_valid <= 1'b1;
               state     <= RESP;
`else
               state     <= IDLE;
`endif
            end
            RESP: begin
               if (rsp_ready) begin
                  rsp_valid <= 1'b0;
                  state     <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
